// File: rtl/tt_nn_pkg.sv
// Shared types and constants for the tt_um NN datapath.
package tt_nn_pkg;

   localparam int DEF_N_ELEM = 16;
   localparam int DEF_DATA_W = 8;

   localparam logic [1:0] W_ZERO = 2'b00;
   localparam logic [1:0] W_POS  = 2'b01;
   localparam logic [1:0] W_RSVD = 2'b10;
   localparam logic [1:0] W_NEG  = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/ternary_neuron_mac_if.sv
// Request/result bundle between the SPI register block, the MAC and its consumer.
interface ternary_neuron_mac_if #(
   parameter int N_ELEM = 16,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 13
);

   logic                       start;
   logic [2*N_ELEM-1:0]        weights;
   logic [N_ELEM*DATA_W-1:0]   data;
   logic                       busy;
   logic                       out_valid;
   logic                       out_ready;
   logic [7:0]                 out_data;
   logic signed [ACC_W-1:0]    out_acc;

   modport master (
      output start, weights, data, out_ready,
      input  busy, out_valid, out_data, out_acc
   );

   modport slave (
      input  start, weights, data, out_ready,
      output busy, out_valid, out_data, out_acc
   );

endinterface

// File: rtl/nn_quantize.sv
// Shift + activation of the raw sum to an 8-bit code.
// TERNARY_NEURON_RELU_EN selects ReLU (unsigned) instead of linear clamp.
module nn_quantize #(
   parameter int ACC_W     = 13,
   parameter int OUT_SHIFT = 4
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic        [7:0]       q
);

   logic signed [ACC_W-1:0] s;

   assign s = acc >>> OUT_SHIFT;

`ifdef TERNARY_NEURON_RELU_EN
   localparam logic signed [ACC_W-1:0] U_MAX = 255;

   always_comb begin
      q = s[7:0];
      if (s < 0)
         q = 8'h00;
      else if (s > U_MAX)
         q = 8'hFF;
   end
`else
   localparam logic signed [ACC_W-1:0] S_MAX = 127;
   localparam logic signed [ACC_W-1:0] S_MIN = -128;

   always_comb begin
      q = s[7:0];
      if (s > S_MAX)
         q = 8'h7F;
      else if (s < S_MIN)
         q = 8'h80;
   end
`endif

endmodule

// File: rtl/ternary_neuron_mac.sv
// Sequential ternary dot product, one element per clock, with
// snapshot on start and a valid/ready result port.
module ternary_neuron_mac
   import tt_nn_pkg::*;
#(
   parameter int N_ELEM    = DEF_N_ELEM,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ACC_W     = 13,
   parameter int OUT_SHIFT = 4
) (
   input logic               clk,
   input logic               rst_n,
   ternary_neuron_mac_if.slave bus
);

   localparam int IDX_W = $clog2(N_ELEM);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ELEM - 1);

   state_t state_q, state_d;

   logic [IDX_W-1:0]          idx_q;
   logic [2*N_ELEM-1:0]       w_q;
   logic [N_ELEM*DATA_W-1:0]  d_q;
   logic signed [ACC_W-1:0]   acc_q;
   logic signed [ACC_W-1:0]   out_acc_q;
   logic [7:0]                out_data_q;

   logic [1:0]                w_cur;
   logic [DATA_W-1:0]         d_cur;
   logic signed [ACC_W-1:0]   d_ext;
   logic signed [ACC_W-1:0]   term;
   logic signed [ACC_W-1:0]   sum;
   logic [7:0]                q_data;
   logic                      last;

   assign w_cur = w_q[2*idx_q +: 2];
   assign d_cur = d_q[idx_q*DATA_W +: DATA_W];
   assign d_ext = ACC_W'(d_cur);
   assign last  = (idx_q == LAST);

   // Reserved code 10 falls through to zero with 00.
   always_comb begin
      term = '0;
      unique case (1'b1)
         (w_cur == W_POS): term = d_ext;
         (w_cur == W_NEG): term = -d_ext;
         default:          term = '0;
      endcase
   end

   assign sum = acc_q + term;

   nn_quantize #(
      .ACC_W     (ACC_W),
      .OUT_SHIFT (OUT_SHIFT)
   ) u_quant (
      .acc (sum),
      .q   (q_data)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (bus.start) state_d = RUN;
         RUN:  if (last) state_d = DONE;
         DONE: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         w_q        <= '0;
         d_q        <= '0;
         acc_q      <= '0;
         out_acc_q  <= '0;
         out_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && bus.start) begin
            w_q   <= bus.weights;
            d_q   <= bus.data;
            acc_q <= '0;
            idx_q <= '0;
         end
         if (state_q == RUN) begin
            acc_q <= sum;
            idx_q <= idx_q + 1'b1;
            if (last) begin
               out_acc_q  <= sum;
               out_data_q <= q_data;
            end
         end
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_data  = out_data_q;
   assign bus.out_acc   = out_acc_q;

endmodule
